// File: rtl/lockin_acquisition_sequencer_pkg.sv
// Shared state encoding and default widths for the lock-in acquisition sequencer.
`default_nettype none

package lockin_acquisition_sequencer_pkg;

   localparam int DEFAULT_CW = 32;
   localparam int DEFAULT_TW = 32;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_GUARD_ON  = 3'd1,
      ST_COUNT_ON  = 3'd2,
      ST_GUARD_OFF = 3'd3,
      ST_COUNT_OFF = 3'd4,
      ST_DONE      = 3'd5
   } state_t;

endpackage

`default_nettype wire

// File: rtl/pmt_pulse_sync.sv
// Two-flop synchronizer for the PMT pin followed by a registered rising-edge strobe.
`default_nettype none

module pmt_pulse_sync (
   input  logic clock_50_mhz,
   input  logic reset,
   input  logic pmt_in,
   output logic strobe
);

   logic meta;
   logic sync;
   logic sync_d;

   // Preset high so a pin already high when reset releases is not seen as an edge.
   always_ff @(posedge clock_50_mhz or posedge reset) begin
      if (reset) begin
         meta   <= 1'b1;
         sync   <= 1'b1;
         sync_d <= 1'b1;
         strobe <= 1'b0;
      end else begin
         meta   <= pmt_in;
         sync   <= meta;
         sync_d <= sync;
         strobe <= sync & ~sync_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/lockin_acquisition_sequencer.sv
// Lock-in photon-counting sequencer: light modulation, guard blanking, gated add/sub
// counting over N periods and a valid/ready result port.
`default_nettype none

module lockin_acquisition_sequencer
   import lockin_acquisition_sequencer_pkg::*;
#(
   parameter int CW = DEFAULT_CW,
   parameter int TW = DEFAULT_TW
) (
   input  logic                 clock_50_mhz,
   input  logic                 reset,
   input  logic                 pmt_in,
   input  logic                 start,
   input  logic                 abort,
   input  logic                 continuous,
   input  logic [TW-1:0]        half_period,
   input  logic [TW-1:0]        guard_cycles,
   input  logic [TW-1:0]        num_periods,
   output logic                 light_source,
   output logic                 gate_on,
   output logic                 gate_off,
   output logic                 busy,
   output logic                 cfg_err,
   output logic                 result_valid,
   input  logic                 result_ready,
   output logic [CW-1:0]        result_add,
   output logic [CW-1:0]        result_sub,
   output logic signed [CW:0]   result_diff
);

   state_t        state;
   state_t        nxt;
   state_t        first_on;
   logic [TW-1:0] hp_q;
   logic [TW-1:0] g_q;
   logic [TW-1:0] np_q;
   logic [TW-1:0] timer;
   logic [TW-1:0] period_cnt;
   logic [CW-1:0] add_cnt;
   logic [CW-1:0] sub_cnt;
   logic [CW-1:0] add_nxt;
   logic [CW-1:0] sub_nxt;
   logic          strobe;
   logic          cfg_ok;
   logic          accept;
   logic          guard_end;
   logic          count_end;
   logic          last_period;
   logic          transfer;

   pmt_pulse_sync u_sync (
      .clock_50_mhz (clock_50_mhz),
      .reset        (reset),
      .pmt_in       (pmt_in),
      .strobe       (strobe)
   );

   always_comb begin
      cfg_ok      = (half_period >= TW'(2)) && (guard_cycles < half_period) && (num_periods != '0);
      accept      = (state == ST_IDLE) && start && cfg_ok;
      guard_end   = (timer == g_q - 1'b1);
      count_end   = (timer == hp_q - g_q - 1'b1);
      last_period = (period_cnt == np_q - 1'b1);
      first_on    = (g_q == '0) ? ST_COUNT_ON : ST_GUARD_ON;
      transfer    = (state == ST_DONE) && result_ready;

      nxt = state;
      if (state != ST_IDLE && abort) begin
         nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE:      if (accept) nxt = (guard_cycles == '0) ? ST_COUNT_ON : ST_GUARD_ON;
            ST_GUARD_ON:  if (guard_end) nxt = ST_COUNT_ON;
            ST_COUNT_ON:  if (count_end) nxt = (g_q == '0) ? ST_COUNT_OFF : ST_GUARD_OFF;
            ST_GUARD_OFF: if (guard_end) nxt = ST_COUNT_OFF;
            ST_COUNT_OFF: if (count_end) nxt = last_period ? ST_DONE : first_on;
            ST_DONE:      if (result_ready) nxt = continuous ? first_on : ST_IDLE;
            default:      nxt = ST_IDLE;
         endcase
      end

      // Saturating counters; a strobe outside the count windows is dropped.
      add_nxt = add_cnt;
      sub_nxt = sub_cnt;
      if (strobe && state == ST_COUNT_ON && add_cnt != '1) add_nxt = add_cnt + 1'b1;
      if (strobe && state == ST_COUNT_OFF && sub_cnt != '1) sub_nxt = sub_cnt + 1'b1;
   end

   always_ff @(posedge clock_50_mhz or posedge reset) begin
      if (reset) begin
         state        <= ST_IDLE;
         hp_q         <= '0;
         g_q          <= '0;
         np_q         <= '0;
         timer        <= '0;
         period_cnt   <= '0;
         add_cnt      <= '0;
         sub_cnt      <= '0;
         light_source <= 1'b0;
         gate_on      <= 1'b0;
         gate_off     <= 1'b0;
         busy         <= 1'b0;
         cfg_err      <= 1'b0;
         result_valid <= 1'b0;
         result_add   <= '0;
         result_sub   <= '0;
         result_diff  <= '0;
      end else begin
         state        <= nxt;
         light_source <= (nxt == ST_GUARD_ON) || (nxt == ST_COUNT_ON);
         gate_on      <= (nxt == ST_COUNT_ON);
         gate_off     <= (nxt == ST_COUNT_OFF);
         busy         <= (nxt != ST_IDLE);
         result_valid <= (nxt == ST_DONE);
         cfg_err      <= (state == ST_IDLE) && start && !cfg_ok;

         // Timer counts cycles spent in the current state.
         if (nxt != state || state == ST_IDLE || state == ST_DONE) timer <= '0;
         else timer <= timer + 1'b1;

         if (accept) begin
            hp_q <= half_period;
            g_q  <= guard_cycles;
            np_q <= num_periods;
         end

         if (nxt == ST_IDLE || transfer) begin
            add_cnt    <= '0;
            sub_cnt    <= '0;
            period_cnt <= '0;
         end else begin
            add_cnt <= add_nxt;
            sub_cnt <= sub_nxt;
            if (state == ST_COUNT_OFF && count_end) period_cnt <= period_cnt + 1'b1;
         end

         // Capture includes a strobe landing in the final COUNT_OFF cycle.
         if (state != ST_DONE && nxt == ST_DONE) begin
            result_add  <= add_nxt;
            result_sub  <= sub_nxt;
            result_diff <= $signed({1'b0, add_nxt}) - $signed({1'b0, sub_nxt});
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_lockin_acquisition_sequencer.sv
// Scoreboard bench for lockin_acquisition_sequencer using directed pulse schedules.
`default_nettype none

module tb_lockin_acquisition_sequencer;

   localparam int CW = 4;
   localparam int TW = 32;

   logic                clock_50_mhz = 1'b0;
   logic                reset = 1'b1;
   logic                pmt_in = 1'b0;
   logic                start = 1'b0;
   logic                abort = 1'b0;
   logic                continuous = 1'b0;
   logic                result_ready = 1'b1;
   logic [TW-1:0]       half_period = '0;
   logic [TW-1:0]       guard_cycles = '0;
   logic [TW-1:0]       num_periods = '0;
   logic                light_source;
   logic                gate_on;
   logic                gate_off;
   logic                busy;
   logic                cfg_err;
   logic                result_valid;
   logic [CW-1:0]       result_add;
   logic [CW-1:0]       result_sub;
   logic signed [CW:0]  result_diff;

   lockin_acquisition_sequencer #(.CW(CW), .TW(TW)) dut (
      .clock_50_mhz (clock_50_mhz),
      .reset        (reset),
      .pmt_in       (pmt_in),
      .start        (start),
      .abort        (abort),
      .continuous   (continuous),
      .half_period  (half_period),
      .guard_cycles (guard_cycles),
      .num_periods  (num_periods),
      .light_source (light_source),
      .gate_on      (gate_on),
      .gate_off     (gate_off),
      .busy         (busy),
      .cfg_err      (cfg_err),
      .result_valid (result_valid),
      .result_ready (result_ready),
      .result_add   (result_add),
      .result_sub   (result_sub),
      .result_diff  (result_diff)
   );

   always #10 clock_50_mhz = ~clock_50_mhz;

   typedef struct {
      int add;
      int sub;
      int diff;
   } exp_t;

   exp_t exp_q[$];
   int   vectors = 0;
   int   miscompares = 0;
   bit   pat[256];
   int   a = -1;

   task automatic chk(input string name, input int act, input int req);
      vectors++;
      if (act != req) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic push_exp(input int add, input int sub, input int diff);
      exp_t e;
      e.add  = add;
      e.sub  = sub;
      e.diff = diff;
      exp_q.push_back(e);
   endtask

   // Monitor: every accepted result is popped and compared against the scoreboard.
   always @(negedge clock_50_mhz) begin
      if (!reset && result_valid && result_ready) begin
         if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_result: add=%0d sub=%0d, no result expected", result_add, result_sub);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("result_add", int'(result_add), e.add);
            chk("result_sub", int'(result_sub), e.sub);
            chk("result_diff", int'(result_diff), e.diff);
         end
      end
   end

   // Pin level pat[k] is driven after absolute edge k; start is driven after edge 4,
   // so relative cycle c = k - 4, and pat[c+1] lands a strobe in relative cycle c.
   task automatic clear_pat();
      for (int i = 0; i < 256; i++) pat[i] = 1'b0;
   endtask

   task automatic pulse_at(input int c);
      pat[c + 1] = 1'b1;
   endtask

   task automatic arm(input int hp, input int g, input int np, input bit cont);
      half_period  = TW'(hp);
      guard_cycles = TW'(g);
      num_periods  = TW'(np);
      continuous   = cont;
      a = -1;
   endtask

   task automatic step();
      @(posedge clock_50_mhz);
      #1;
      a++;
      pmt_in = (a >= 0 && a < 256) ? pat[a] : 1'b0;
      start  = (a == 4);
   endtask

   task automatic go_to(input int c);
      while (a - 4 < c) step();
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         @(posedge clock_50_mhz);
         n++;
      end
      if (exp_q.size() != 0) begin
         vectors++;
         miscompares++;
         $display("FAIL result_timeout: %0d results outstanding, expected 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      clear_pat();
      repeat (3) @(posedge clock_50_mhz);
      #1;
      chk("reset_light", int'(light_source), 0);
      chk("reset_busy", int'(busy), 0);
      chk("reset_gate_on", int'(gate_on), 0);
      chk("reset_gate_off", int'(gate_off), 0);
      chk("reset_cfg_err", int'(cfg_err), 0);
      chk("reset_valid", int'(result_valid), 0);
      chk("reset_add", int'(result_add), 0);
      chk("reset_diff", int'(result_diff), 0);
      reset = 1'b0;

      // Test 1: one pulse per COUNT_ON window, light and gate timing per cycle.
      clear_pat();
      pulse_at(6); pulse_at(26); pulse_at(46);
      push_exp(3, 0, 3);
      arm(10, 2, 3, 1'b0);
      for (int c = 1; c <= 60; c++) begin
         go_to(c);
         chk("t1_light", int'(light_source), (((c - 1) % 20) < 10) ? 1 : 0);
         chk("t1_gate_on", int'(gate_on), (((c - 1) % 20) >= 2 && ((c - 1) % 20) <= 9) ? 1 : 0);
         chk("t1_gate_off", int'(gate_off), (((c - 1) % 20) >= 12) ? 1 : 0);
      end
      go_to(61);
      chk("t1_done_valid", int'(result_valid), 1);
      go_to(62);
      chk("t1_idle_busy", int'(busy), 0);
      drain();

      // Test 2: pulses in guard windows dropped, last COUNT_OFF cycle counted.
      clear_pat();
      pulse_at(2); pulse_at(11); pulse_at(20);
      push_exp(0, 1, 1 - 2);
      arm(10, 2, 1, 1'b0);
      go_to(23);
      drain();

      // Test 3: invalid configurations.
      clear_pat();
      arm(10, 10, 1, 1'b0);
      go_to(1);
      chk("t3a_cfg_err", int'(cfg_err), 1);
      chk("t3a_busy", int'(busy), 0);
      go_to(2);
      chk("t3a_cfg_err_clear", int'(cfg_err), 0);
      chk("t3a_light", int'(light_source), 0);
      arm(10, 2, 0, 1'b0);
      go_to(1);
      chk("t3b_cfg_err", int'(cfg_err), 1);
      chk("t3b_busy", int'(busy), 0);
      arm(1, 0, 1, 1'b0);
      go_to(1);
      chk("t3c_cfg_err", int'(cfg_err), 1);
      chk("t3c_busy", int'(busy), 0);
      go_to(3);

      // Test 4: 20 pulses in COUNT_OFF saturate the 4-bit subtract counter.
      clear_pat();
      for (int k = 0; k < 10; k++) begin
         pulse_at(34 + 2 * k);
         pulse_at(94 + 2 * k);
      end
      push_exp(0, 15, -15);
      arm(30, 2, 2, 1'b0);
      go_to(123);
      drain();

      // Test 5: held result while not ready, then continuous re-arm.
      clear_pat();
      pulse_at(2); pulse_at(4); pulse_at(7);
      push_exp(2, 1, 1);
      result_ready = 1'b0;
      arm(4, 1, 1, 1'b1);
      for (int c = 9; c <= 13; c++) begin
         go_to(c);
         chk("t5_hold_valid", int'(result_valid), 1);
         chk("t5_hold_add", int'(result_add), 2);
         chk("t5_hold_sub", int'(result_sub), 1);
         chk("t5_hold_diff", int'(result_diff), 1);
      end
      result_ready = 1'b1;
      go_to(14);
      chk("t5_rearm_valid", int'(result_valid), 0);
      chk("t5_rearm_busy", int'(busy), 1);
      chk("t5_rearm_light", int'(light_source), 1);
      chk("t5_rearm_gate_on", int'(gate_on), 0);
      push_exp(0, 0, 0);
      continuous  = 1'b0;
      half_period = TW'(50);
      go_to(22);
      chk("t5_second_valid", int'(result_valid), 1);
      go_to(23);
      chk("t5_second_busy", int'(busy), 0);
      drain();

      // Test 6: abort mid-COUNT_ON, then a zero-guard run shows counters cleared.
      clear_pat();
      pulse_at(4);
      arm(10, 2, 1, 1'b0);
      go_to(5);
      abort = 1'b1;
      go_to(6);
      abort = 1'b0;
      chk("t6_abort_busy", int'(busy), 0);
      chk("t6_abort_light", int'(light_source), 0);
      chk("t6_abort_gate_on", int'(gate_on), 0);
      chk("t6_abort_valid", int'(result_valid), 0);
      for (int c = 7; c <= 30; c++) begin
         go_to(c);
         if (c % 8 == 0) chk("t6_no_result", int'(result_valid), 0);
      end
      clear_pat();
      push_exp(0, 0, 0);
      arm(4, 0, 1, 1'b0);
      go_to(1);
      chk("t6_g0_gate_on", int'(gate_on), 1);
      chk("t6_g0_light", int'(light_source), 1);
      go_to(10);
      drain();

      // Reset asserted during DONE clears outputs immediately.
      clear_pat();
      pulse_at(3);
      result_ready = 1'b0;
      arm(4, 1, 1, 1'b0);
      go_to(10);
      chk("rst_pre_valid", int'(result_valid), 1);
      reset = 1'b1;
      #1;
      chk("rst_valid", int'(result_valid), 0);
      chk("rst_add", int'(result_add), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_light", int'(light_source), 0);
      chk("rst_diff", int'(result_diff), 0);
      for (int i = 0; i < 6; i++) begin
         @(posedge clock_50_mhz);
         #1;
         pmt_in = (i % 2 == 0) ? 1'b1 : 1'b0;
      end
      pmt_in = 1'b1;
      @(posedge clock_50_mhz);
      #1;
      reset = 1'b0;
      result_ready = 1'b1;
      clear_pat();
      push_exp(0, 0, 0);
      arm(4, 0, 1, 1'b0);
      go_to(10);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
